// File: rtl/sccomp_trace_pkg.sv
// sccomp_trace_pkg
// Shared definitions for the retire-trace capture unit.
//   trace_state_t : capture controller states
//   CH_*          : channel positions inside one packed sample
//   TS_W          : width of the optional per-sample cycle stamp
package sccomp_trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DRAIN = 2'd3
    } trace_state_t;

    localparam int CH_PC   = 0;
    localparam int CH_INST = 1;
    localparam int CH_ALU  = 2;
    localparam int CH_MEM  = 3;

    localparam int TS_W = 16;

endpackage

// File: rtl/sccomp_trace_ram.sv
// sccomp_trace_ram
// Simple dual-port storage for the trace ring: one write port and one
// registered read port. The read register only loads when rd_en is high, so
// the value it presents stays put while the consumer stalls.
// Ports:
//   clock, reset        : clock and asynchronous active-high reset (read register only)
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr       : read request, data appears on rd_data after the edge
//   rd_data             : registered read data
module sccomp_trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 128,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array has no reset so it can map onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register is reset so the read port reads zero straight out of reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sccomp_trace_buffer.sv
// sccomp_trace_buffer
// Retire-trace capture unit. Records one sample per retired instruction into a
// ring buffer, freezes a programmable number of samples after a PC-match
// trigger, then streams the captured window oldest-first on a valid/ready port.
// Optional build macro: SCCOMP_TRACE_TIMESTAMP_EN adds a free-running 16-bit
// cycle stamp stored with every sample and presented on rd_ts.
// Ports:
//   clock, reset          : clock, asynchronous active-high reset
//   arm, abort            : start a capture (IDLE only) / discard and go idle
//   cap_valid, cap_data   : retired-instruction sample, channel k at [k*DATA_W +: DATA_W]
//   trig_pc, trig_mask    : trigger compare value and bit mask
//   rd_valid, rd_ready    : drain handshake
//   rd_data, rd_last      : drained sample and end-of-window marker
//   busy, triggered, wrapped : status
//   rd_ts                 : sample timestamp (only with SCCOMP_TRACE_TIMESTAMP_EN)
module sccomp_trace_buffer
    import sccomp_trace_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int CHANNELS  = 4,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       arm,
    input  logic                       abort,
    input  logic                       cap_valid,
    input  logic [CHANNELS*DATA_W-1:0] cap_data,
    input  logic [DATA_W-1:0]          trig_pc,
    input  logic [DATA_W-1:0]          trig_mask,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [CHANNELS*DATA_W-1:0] rd_data,
    output logic                       rd_last,
    output logic                       busy,
    output logic                       triggered,
    output logic                       wrapped
`ifdef SCCOMP_TRACE_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]            rd_ts
`endif
);

    localparam int AW       = $clog2(DEPTH);
    localparam int SAMPLE_W = CHANNELS * DATA_W;
`ifdef SCCOMP_TRACE_TIMESTAMP_EN
    localparam int ENTRY_W  = SAMPLE_W + TS_W;
`else
    localparam int ENTRY_W  = SAMPLE_W;
`endif
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

    trace_state_t state;
    trace_state_t state_next;

    logic [AW-1:0]      wr_ptr;
    logic [AW:0]        count;
    logic [AW:0]        fetched;
    logic [AW-1:0]      post_cnt;
    logic [AW-1:0]      rd_addr;
    logic               pc_match;
    logic               wr_en;
    logic               trig_hit;
    logic               accept;
    logic               fetch;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // Trigger compare and the qualified events that drive both the FSM and the
    // datapath. abort blocks every write and every drain beat in its cycle.
    always_comb begin
        pc_match = ((cap_data[CH_PC*DATA_W +: DATA_W] ^ trig_pc) & trig_mask) == '0;
        wr_en    = cap_valid && !abort && ((state == ARMED) || (state == POST));
        trig_hit = cap_valid && !abort && (state == ARMED) && pc_match;
        accept   = (state == DRAIN) && !abort && rd_valid && rd_ready;
        fetch    = (state == DRAIN) && !abort && (fetched != count)
                   && (!rd_valid || rd_ready);
    end

    // Write and wrap pointers are frozen during DRAIN, so the oldest entry is
    // wr_ptr - count and each fetch walks forward from it. A full buffer has
    // count == DEPTH, whose low bits are zero, giving wr_ptr itself.
    always_comb begin
        rd_addr = wr_ptr - count[AW-1:0] + fetched[AW-1:0];
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. abort wins over arm, trigger, post-window writes and
    // the final drain handshake.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        state_next = ARMED;
                    end
                end
                ARMED: begin
                    if (trig_hit) begin
                        state_next = (POST_TRIG == 0) ? DRAIN : POST;
                    end
                end
                POST: begin
                    if (wr_en && (post_cnt == AW'(1))) begin
                        state_next = DRAIN;
                    end
                end
                DRAIN: begin
                    if (accept && rd_last) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Capture bookkeeping: ring pointer, saturating fill count, wrap flag,
    // trigger flag and the post-trigger countdown.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            count     <= '0;
            wrapped   <= 1'b0;
            triggered <= 1'b0;
            post_cnt  <= '0;
        end else begin
            if ((state == IDLE) && arm && !abort) begin
                wr_ptr    <= '0;
                count     <= '0;
                wrapped   <= 1'b0;
                triggered <= 1'b0;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (count == FULL_CNT) begin
                    wrapped <= 1'b1;
                end else begin
                    count <= count + (AW+1)'(1);
                end
            end
            if (trig_hit) begin
                triggered <= 1'b1;
                post_cnt  <= POST_INIT;
            end else if ((state == POST) && wr_en) begin
                post_cnt <= post_cnt - AW'(1);
            end
        end
    end

    // Drain side. A fetch loads the RAM read register; rd_valid follows it by
    // one edge. The next entry is fetched on the same edge that accepts the
    // current one, so a continuously ready consumer gets one beat per cycle,
    // and a stalled consumer sees the read register untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetched  <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            if ((state == IDLE) && arm && !abort) begin
                fetched <= '0;
            end else if (fetch) begin
                fetched <= fetched + (AW+1)'(1);
            end
            if (abort) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end else if (fetch) begin
                rd_valid <= 1'b1;
                rd_last  <= ((fetched + (AW+1)'(1)) == count);
            end else if (accept) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end
        end
    end

`ifdef SCCOMP_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    // Free-running cycle stamp, wraps naturally at 16 bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
        end
    end

    // The stamp rides in the top bits of each entry.
    always_comb begin
        wr_entry = {ts_cnt, cap_data};
        rd_data  = rd_entry[SAMPLE_W-1:0];
        rd_ts    = rd_entry[ENTRY_W-1 -: TS_W];
    end
`else
    // Entries hold the bare sample.
    always_comb begin
        wr_entry = cap_data;
        rd_data  = rd_entry;
    end
`endif

    // Status output.
    always_comb begin
        busy = (state != IDLE);
    end

    sccomp_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_en   (fetch),
        .rd_addr (rd_addr),
        .rd_data (rd_entry)
    );

endmodule

// File: tb/tb_sccomp_trace_buffer.sv
// tb_sccomp_trace_buffer
// Self-checking bench for sccomp_trace_buffer. A table of trigger setups with
// hand-derived window expectations drives a main instance (POST_TRIG=8); a
// scoreboard queue of written samples is compared against every drain beat.
// A second instance with POST_TRIG=0 covers the single-entry window.
module tb_sccomp_trace_buffer;

    localparam int DW  = 32;
    localparam int CH  = 4;
    localparam int DEP = 16;
    localparam int PT  = 8;
    localparam int EW  = CH * DW;

    logic          clock = 1'b0;
    logic          reset;
    logic          arm;
    logic          abort;
    logic          cap_valid;
    logic [EW-1:0] cap_data;
    logic [DW-1:0] trig_pc;
    logic [DW-1:0] trig_mask;
    logic          rd_valid;
    logic          rd_ready;
    logic [EW-1:0] rd_data;
    logic          rd_last;
    logic          busy;
    logic          triggered;
    logic          wrapped;

    logic          armz;
    logic          cvz;
    logic [DW-1:0] maskz;
    logic          rd_valid_z;
    logic [EW-1:0] rd_data_z;
    logic          rd_last_z;
    logic          busy_z;
    logic          triggered_z;
    logic          wrapped_z;

`ifdef SCCOMP_TRACE_TIMESTAMP_EN
    logic [15:0]   rd_ts;
    logic [15:0]   rd_ts_z;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [EW-1:0] expQ [$];

    typedef struct {
        logic [DW-1:0] tpc;
        logic [DW-1:0] tmask;
        int            expBeats;
        logic [DW-1:0] expFirstPc;
        logic          expWrapped;
    } vec_t;

    vec_t vecs [4];

    always #5 clock = ~clock;

    sccomp_trace_buffer #(
        .DATA_W    (DW),
        .CHANNELS  (CH),
        .DEPTH     (DEP),
        .POST_TRIG (PT)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .arm       (arm),
        .abort     (abort),
        .cap_valid (cap_valid),
        .cap_data  (cap_data),
        .trig_pc   (trig_pc),
        .trig_mask (trig_mask),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy),
        .triggered (triggered),
        .wrapped   (wrapped)
`ifdef SCCOMP_TRACE_TIMESTAMP_EN
        ,
        .rd_ts     (rd_ts)
`endif
    );

    sccomp_trace_buffer #(
        .DATA_W    (DW),
        .CHANNELS  (CH),
        .DEPTH     (DEP),
        .POST_TRIG (0)
    ) u_zero (
        .clock     (clock),
        .reset     (reset),
        .arm       (armz),
        .abort     (abort),
        .cap_valid (cvz),
        .cap_data  (cap_data),
        .trig_pc   (trig_pc),
        .trig_mask (maskz),
        .rd_valid  (rd_valid_z),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data_z),
        .rd_last   (rd_last_z),
        .busy      (busy_z),
        .triggered (triggered_z),
        .wrapped   (wrapped_z)
`ifdef SCCOMP_TRACE_TIMESTAMP_EN
        ,
        .rd_ts     (rd_ts_z)
`endif
    );

    // Builds a recognisable sample from a pc: {memout, aluout, inst, pc}.
    function automatic logic [EW-1:0] mkSample(input logic [DW-1:0] pc);
        return {pc ^ 32'hA5A5_A5A5, pc + 32'd1, ~pc, pc};
    endfunction

    task automatic checkOutput(input string name, input logic [EW-1:0] act,
                               input logic [EW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: bound expired, got timeout, expected completion", name);
    endtask

    // Drives one capture cycle and returns one edge later (#1 after posedge).
    task automatic applyStimulus(input logic cv, input logic [DW-1:0] pc);
        cap_valid = cv;
        cap_data  = mkSample(pc);
        @(posedge clock);
        #1;
        cap_valid = 1'b0;
    endtask

    // Arms the main instance and feeds incrementing pcs with random retire
    // gaps until the reference model says the capture has frozen. Every
    // accepted sample goes into the scoreboard, keeping only the newest DEP.
    task automatic runCapture(input logic [DW-1:0] tpc, input logic [DW-1:0] tmask);
        int            ms;
        int            postLeft;
        logic [DW-1:0] pc;
        logic          cv;
        trig_pc   = tpc;
        trig_mask = tmask;
        arm       = 1'b1;
        @(posedge clock);
        #1;
        arm = 1'b0;
        checkOutput("armed_busy", busy, 1);
        checkOutput("armed_triggered_clear", triggered, 0);
        expQ.delete();
        ms       = 1;
        postLeft = 0;
        pc       = '0;
        for (int cyc = 0; cyc < 300 && ms != 3; cyc++) begin
            cv = ($urandom_range(0, 3) != 0);
            if (cv) begin
                if (expQ.size() == DEP) begin
                    void'(expQ.pop_front());
                end
                expQ.push_back(mkSample(pc));
                if (ms == 1 && ((pc ^ tpc) & tmask) == '0) begin
                    ms       = (PT == 0) ? 3 : 2;
                    postLeft = PT;
                end else if (ms == 2) begin
                    postLeft--;
                    if (postLeft == 0) begin
                        ms = 3;
                    end
                end
            end
            applyStimulus(cv, pc);
            if (cv) begin
                pc = pc + 32'd4;
            end
        end
        if (ms != 3) begin
            reportTimeout("capture_feed");
        end
    endtask

    // Drains the window under random backpressure, holding arm for the first
    // few cycles, and scores every accepted beat.
    task automatic drainCheck(output int beats, output logic [DW-1:0] firstPc);
        logic          stalled;
        logic [EW-1:0] held;
        logic [EW-1:0] exp;
        bit            done;
`ifdef SCCOMP_TRACE_TIMESTAMP_EN
        logic [15:0]   lastTs;
`endif
        beats   = 0;
        firstPc = '0;
        stalled = 1'b0;
        held    = '0;
        done    = 0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            rd_ready = ($urandom_range(0, 2) != 0);
            arm      = (cyc < 3);
            @(negedge clock);
            if (stalled && rd_valid) begin
                checkOutput("stall_hold_data", rd_data, held);
            end
            if (rd_valid && rd_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("extra_beat", 1, 0);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("beat_data", rd_data, exp);
                    checkOutput("beat_last", rd_last, (expQ.size() == 0));
                end
`ifdef SCCOMP_TRACE_TIMESTAMP_EN
                if (beats > 0) begin
                    checkOutput("ts_increasing", (rd_ts > lastTs), 1);
                end
                lastTs = rd_ts;
`endif
                if (beats == 0) begin
                    firstPc = rd_data[DW-1:0];
                end
                beats++;
                if (rd_last) begin
                    done = 1;
                end
            end
            stalled = rd_valid && !rd_ready;
            held    = rd_data;
            @(posedge clock);
            #1;
        end
        arm      = 1'b0;
        rd_ready = 1'b0;
        if (!done) begin
            reportTimeout("drain");
        end
        checkOutput("busy_after_last", busy, 0);
        checkOutput("valid_after_last", rd_valid, 0);
    endtask

    initial begin
        int            beats;
        logic [DW-1:0] firstPc;

        vecs[0] = '{tpc: 32'h40, tmask: 32'hFFFF_FFFF, expBeats: 16, expFirstPc: 32'h24, expWrapped: 1'b1};
        vecs[1] = '{tpc: 32'h08, tmask: 32'hFFFF_FFFF, expBeats: 11, expFirstPc: 32'h00, expWrapped: 1'b0};
        vecs[2] = '{tpc: 32'h1234, tmask: 32'h0, expBeats: 9, expFirstPc: 32'h00, expWrapped: 1'b0};
        vecs[3] = '{tpc: 32'h3C, tmask: 32'hFFFF_FFF0, expBeats: 16, expFirstPc: 32'h14, expWrapped: 1'b1};

        reset     = 1'b1;
        arm       = 1'b0;
        abort     = 1'b0;
        cap_valid = 1'b0;
        cap_data  = '0;
        trig_pc   = '0;
        trig_mask = '0;
        rd_ready  = 1'b0;
        armz      = 1'b0;
        cvz       = 1'b0;
        maskz     = '0;
        #23;
        checkOutput("reset_rd_valid", rd_valid, 0);
        checkOutput("reset_rd_last", rd_last, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_triggered", triggered, 0);
        checkOutput("reset_wrapped", wrapped, 0);
        checkOutput("reset_rd_data", rd_data, 0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 4; i++) begin
            runCapture(vecs[i].tpc, vecs[i].tmask);
            checkOutput("frozen_busy", busy, 1);
            checkOutput("frozen_triggered", triggered, 1);
            checkOutput("frozen_wrapped", wrapped, vecs[i].expWrapped);
            drainCheck(beats, firstPc);
            checkOutput("window_beats", beats, vecs[i].expBeats);
            checkOutput("window_first_pc", firstPc, vecs[i].expFirstPc);
        end

        // Abort in POST together with a retire: idle next cycle, nothing drains.
        trig_pc   = 32'h08;
        trig_mask = 32'hFFFF_FFFF;
        arm       = 1'b1;
        @(posedge clock);
        #1;
        arm = 1'b0;
        applyStimulus(1'b1, 32'h00);
        applyStimulus(1'b1, 32'h04);
        applyStimulus(1'b1, 32'h08);
        checkOutput("abort_pre_triggered", triggered, 1);
        abort = 1'b1;
        applyStimulus(1'b1, 32'h0C);
        abort = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_rd_valid", rd_valid, 0);
        repeat (3) @(posedge clock);
        #1;
        checkOutput("abort_stays_idle", busy, 0);

        // Reset in the middle of a drain clears every output at once.
        runCapture(vecs[0].tpc, vecs[0].tmask);
        rd_ready = 1'b1;
        repeat (4) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midreset_rd_valid", rd_valid, 0);
        checkOutput("midreset_rd_last", rd_last, 0);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_triggered", triggered, 0);
        checkOutput("midreset_wrapped", wrapped, 0);
        checkOutput("midreset_rd_data", rd_data, 0);
        rd_ready = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        runCapture(vecs[2].tpc, vecs[2].tmask);
        drainCheck(beats, firstPc);
        checkOutput("post_reset_beats", beats, vecs[2].expBeats);
        checkOutput("post_reset_first_pc", firstPc, 32'h00);

        // POST_TRIG=0 with an all-zero mask: first sample is the whole window.
        maskz = '0;
        armz  = 1'b1;
        @(posedge clock);
        #1;
        armz     = 1'b0;
        cvz      = 1'b1;
        cap_data = mkSample(32'h100);
        @(posedge clock);
        #1;
        cvz = 1'b0;
        checkOutput("zero_busy", busy_z, 1);
        checkOutput("zero_triggered", triggered_z, 1);
        checkOutput("zero_valid_latency", rd_valid_z, 0);
        @(posedge clock);
        #1;
        checkOutput("zero_rd_valid", rd_valid_z, 1);
        checkOutput("zero_rd_data", rd_data_z, mkSample(32'h100));
        checkOutput("zero_rd_last", rd_last_z, 1);
        checkOutput("zero_wrapped", wrapped_z, 0);
        rd_ready = 1'b1;
        @(posedge clock);
        #1;
        rd_ready = 1'b0;
        checkOutput("zero_busy_done", busy_z, 0);
        checkOutput("zero_valid_done", rd_valid_z, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sccomp_trace_buffer.md
# sccomp_trace_buffer

Synthesizable retire-trace capture unit for the single-cycle CPU dataflow top. It records the per-instruction signal set (pc, inst, aluout, memout) into an on-chip ring buffer and freezes on a PC-match trigger with a programmable post-trigger window. It then streams the captured window out oldest-first over a valid/ready port. It sits beside the CPU core in the top-level and is generalised in width, depth and channel count.

## Interface
- DATA_W, 32, width of one traced channel
- CHANNELS, 4, channels per sample; channel 0 is always the PC (order: pc, inst, aluout, memout)
- DEPTH, 16, ring-buffer entries; power of two, >= 4
- POST_TRIG, 8, samples stored after the trigger sample; 0 <= POST_TRIG < DEPTH
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- arm  in  1  start a capture; honoured only in IDLE
- abort  in  1  return to IDLE from any state; the buffer is discarded
- cap_valid  in  1  core retired an instruction this cycle
- cap_data  in  CHANNELS*DATA_W  sample; channel k at bits [k*DATA_W +: DATA_W]
- trig_pc  in  DATA_W  trigger compare value
- trig_mask  in  DATA_W  compare mask; 1 = bit compared, all-zero = trigger on the first sample
- rd_valid  out  1  rd_data holds a valid entry
- rd_ready  in  1  consumer accepts the entry
- rd_data  out  CHANNELS*DATA_W  captured sample
- rd_last  out  1  qualifies the final entry of the window
- busy  out  1  state != IDLE
- triggered  out  1  trigger seen in the current capture
- wrapped  out  1  pre-trigger history overwrote at least one entry

## Operation
- States: IDLE, ARMED, POST, DRAIN.
- IDLE: no writes. arm resets the write pointer and entry count to 0, clears triggered and wrapped, and moves to ARMED.
- ARMED: each cap_valid writes cap_data at wr_ptr, then wr_ptr increments modulo DEPTH. count saturates at DEPTH. A write while count==DEPTH sets wrapped.
- Trigger: cap_valid && ((cap_data[pc] ^ trig_pc) & trig_mask)==0 while in ARMED. The trigger sample is stored and triggered is set. With POST_TRIG==0 the next state is DRAIN; otherwise it is POST with post_cnt=POST_TRIG.
- POST: each cap_valid stores a sample and decrements post_cnt. The write that brings post_cnt to 0 moves to DRAIN. cap_valid is ignored outside ARMED and POST.
- DRAIN: the read pointer starts at the oldest entry, which is wr_ptr-count mod DEPTH. Entries are emitted in write order, one per rd_valid&&rd_ready beat, for count beats. rd_last is high on beat count-1. The beat that accepts rd_last moves to IDLE.
- arm outside IDLE is ignored. abort has priority over every other event and over a simultaneous handshake. rd_valid drops in the cycle after abort.
- Reset: state=IDLE, all pointers and counters are 0, and rd_valid, rd_last, busy, triggered and wrapped are all 0. rd_data is 0.

## Timing
- Capture write occurs on the edge that samples cap_valid. Trigger detection is combinational on the same sample, and the state change is visible the next cycle.
- rd_valid rises 1 cycle after entering DRAIN, because the RAM read is registered. rd_data must be held stable while rd_valid && !rd_ready.
- Back-to-back beats are supported: with rd_ready held high, one entry is delivered per cycle. The next entry is prefetched on acceptance.
- busy falls in the cycle after the rd_last handshake. arm is accepted that same cycle.

## Configuration
- Macro: SCCOMP_TRACE_TIMESTAMP_EN.
- Defined:
  - A free-running 16-bit cycle counter is added. It is reset to 0, increments every cycle, and wraps.
  - The counter value is stored with each sample and presented on the extra output port rd_ts [15:0], aligned with rd_data.
- Undefined: no counter, no rd_ts port, and no extra storage.

## Structure
- Package sccomp_trace_pkg holds:
  - the state enum (IDLE, ARMED, POST, DRAIN);
  - the channel index constants CH_PC=0, CH_INST=1, CH_ALU=2, CH_MEM=3;
  - the TS_W=16 constant.
- Sub-module sccomp_trace_ram: simple dual-port RAM (DEPTH x entry width), one write port, registered read port. Entry width is CHANNELS*DATA_W, plus TS_W when SCCOMP_TRACE_TIMESTAMP_EN is defined.

## Test plan
- Reset mid-DRAIN at an arbitrary time → all outputs 0 immediately, state IDLE. The next arm starts with count=0.
- DEPTH=16, POST_TRIG=8, trig_mask=all-ones, trig_pc=0x40. Retire pc=0x00,0x04,…; the trigger falls at sample 16 → 16 entries drained: pc 0x24…0x60, rd_last on 0x60, wrapped=1, triggered=1.
- Trigger on the 3rd sample (pc=0x08) with POST_TRIG=2 → 5 entries drained: 0x00..0x10, wrapped=0.
- POST_TRIG=0, trig_mask=0 → the first sample triggers and DRAIN holds exactly 1 entry with rd_last=1.
- Random rd_ready backpressure during DRAIN → rd_data stable while stalled, no entry lost or duplicated; arm asserted during DRAIN is ignored.
- abort asserted in POST together with cap_valid → no write, IDLE next cycle, busy=0; with SCCOMP_TRACE_TIMESTAMP_EN defined, rd_ts is strictly increasing across the drained window.
